// File: rtl/mem_responder.sv
// mem_responder: byte-wide memory serving instruction fetches and data loads/stores
// with programmable wait states, a one-cycle done pulse and a combinational stall.
module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                d_rd,
    input  logic                d_wr,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic [2*DATA_W-1:0] instr_rdata,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                done,
    output logic                busy,
    output logic                stall,
    output logic                conflict
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_FETCH, OP_LOAD, OP_STORE} op_t;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    state_t state, state_nx;
    op_t op;
    logic armed, beat;
    logic [3:0] cnt;
    logic [ADDR_W-1:0] addr, addr_p1;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem [0:2**ADDR_W-1];
    logic any_req, accept, both_d;
    assign any_req  = if_req | d_rd | d_wr;
    assign both_d   = d_rd & d_wr;
    assign accept   = (state == S_IDLE) && armed && any_req;
    assign addr_p1  = addr + ADDR_W'(1);
    assign done     = (state == S_DONE);
    assign busy     = (state != S_IDLE);
    assign stall    = any_req && !done;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: state_nx = !accept ? S_IDLE : both_d ? S_DONE :
                               (WAIT_CYCLES > 0) ? S_WAIT : S_XFER;
            S_WAIT: state_nx = (cnt == 4'd0) ? S_XFER : S_WAIT;
            S_XFER: state_nx = (op == OP_FETCH && !beat) ? S_XFER : S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end
    // A request held across its own completion stays disarmed until all requests drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed       <= 1'b1;
            op          <= OP_NONE;
            addr        <= '0;
            wdata       <= '0;
            cnt         <= '0;
            beat        <= 1'b0;
            instr_rdata <= '0;
            d_rdata     <= '0;
            conflict    <= 1'b0;
        end else begin
            armed    <= !any_req ? 1'b1 : accept ? 1'b0 : armed;
            conflict <= accept && (both_d || (if_req && (d_rd || d_wr)));
            if (accept) begin
                op    <= both_d ? OP_NONE : d_wr ? OP_STORE : d_rd ? OP_LOAD : OP_FETCH;
                addr  <= (d_rd || d_wr) ? d_addr : if_addr;
                wdata <= d_wdata;
                cnt   <= WAIT_LOAD;
                beat  <= 1'b0;
            end
            if (state == S_WAIT) cnt <= cnt - 4'd1;
            if (state == S_XFER) begin
                beat <= 1'b1;
                if (op == OP_FETCH && !beat) instr_rdata[2*DATA_W-1 -: DATA_W] <= mem[addr];
                if (op == OP_FETCH && beat)  instr_rdata[DATA_W-1:0] <= mem[addr_p1];
                if (op == OP_LOAD)           d_rdata <= mem[addr];
            end
        end
    end
    always_ff @(posedge clk)
        if (state == S_XFER && op == OP_STORE) mem[addr] <= wdata;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of mem_responder with WAIT_CYCLES=2 (dut0) and 0 (dut1);
// both instances share the request inputs so their memories hold identical contents.
module tb_mem_responder;
    logic clk = 0, rst = 0;
    logic if_req = 0, d_rd = 0, d_wr = 0;
    logic [7:0] if_addr = 0, d_addr = 0, d_wdata = 0;
    logic [15:0] instr_rdata0, instr_rdata1;
    logic [7:0] d_rdata0, d_rdata1;
    logic done0, done1, busy0, busy1, stall0, stall1, conflict0, conflict1;
    int tests = 0, fails = 0;
    int lat, stalls, confl;
    always #5 clk = ~clk;

    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_rd(d_rd), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .instr_rdata(instr_rdata0), .d_rdata(d_rdata0),
        .done(done0), .busy(busy0), .stall(stall0), .conflict(conflict0));
    mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_rd(d_rd), .d_wr(d_wr),
        .d_addr(d_addr), .d_wdata(d_wdata), .instr_rdata(instr_rdata1), .d_rdata(d_rdata1),
        .done(done1), .busy(busy1), .stall(stall1), .conflict(conflict1));

    // Called at a negedge right after driving a request: that cycle is T0, lat counts cycles to done.
    task automatic wait_done(input bit fast, output int l, output int s, output int c);
        l = -1; s = 0; c = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            c += int'(fast ? conflict1 : conflict0);
            if (fast ? done1 : done0) begin l = k; break; end
            s += int'(fast ? stall1 : stall0);
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_op(input bit fast, input logic ir, rd, wr, input logic [7:0] ia, da, wd,
                         output int l, output int s, output int c);
        if_req = ir; d_rd = rd; d_wr = wr; if_addr = ia; d_addr = da; d_wdata = wd;
        wait_done(fast, l, s, c);
        if_req = 0; d_rd = 0; d_wr = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        tests++; if ({instr_rdata0, d_rdata0} !== 24'h0) begin fails++; $display("FAIL reset_rdata got %h want 000000", {instr_rdata0, d_rdata0}); end
        tests++; if ({done0, busy0, conflict0, stall0} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b want 0000", {done0, busy0, conflict0, stall0}); end
        tests++; if ({done1, busy1, conflict1, d_rdata1} !== 11'h0) begin fails++; $display("FAIL reset_dut1 got %h want 000", {done1, busy1, conflict1, d_rdata1}); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_store();
        do_op(0, 0, 0, 1, 8'h00, 8'h10, 8'hA5, lat, stalls, confl);
        tests++; if (lat !== 4) begin fails++; $display("FAIL store_latency got %0d want 4", lat); end
        tests++; if (stalls !== 4) begin fails++; $display("FAIL store_stall_cycles got %0d want 4", stalls); end
        tests++; if (stall0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL store_idle got stall=%b busy=%b want 0 0", stall0, busy0); end
    endtask

    task automatic test_held_load();
        int first, pulses;
        first = -1; pulses = 0;
        d_rd = 1; d_addr = 8'h10;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (done0) begin pulses++; if (first < 0) first = k; end
            @(negedge clk);
            #1;
        end
        tests++; if (first !== 4) begin fails++; $display("FAIL held_load_latency got %0d want 4", first); end
        tests++; if (pulses !== 1) begin fails++; $display("FAIL held_load_pulses got %0d want 1", pulses); end
        tests++; if (d_rdata0 !== 8'hA5) begin fails++; $display("FAIL held_load_data got %h want a5", d_rdata0); end
        d_rd = 0;
        repeat (2) @(negedge clk);
        do_op(0, 0, 1, 0, 8'h00, 8'h10, 8'h00, lat, stalls, confl);
        tests++; if (lat !== 4) begin fails++; $display("FAIL rearm_load_latency got %0d want 4", lat); end
    endtask

    task automatic test_fetch_wrap();
        do_op(0, 0, 0, 1, 8'h00, 8'hFF, 8'h12, lat, stalls, confl);
        do_op(0, 0, 0, 1, 8'h00, 8'h00, 8'h34, lat, stalls, confl);
        do_op(0, 0, 0, 1, 8'h00, 8'h01, 8'h56, lat, stalls, confl);
        do_op(0, 1, 0, 0, 8'hFF, 8'h00, 8'h00, lat, stalls, confl);
        tests++; if (lat !== 5) begin fails++; $display("FAIL fetch_latency got %0d want 5", lat); end
        tests++; if (instr_rdata0 !== 16'h1234) begin fails++; $display("FAIL fetch_wrap_data got %h want 1234", instr_rdata0); end
        do_op(0, 1, 0, 0, 8'h00, 8'h00, 8'h00, lat, stalls, confl);
        tests++; if (instr_rdata0 !== 16'h3456) begin fails++; $display("FAIL fetch_data got %h want 3456", instr_rdata0); end
        tests++; if (d_rdata0 !== 8'hA5) begin fails++; $display("FAIL fetch_keeps_drdata got %h want a5", d_rdata0); end
    endtask

    task automatic test_conflict();
        do_op(0, 1, 1, 0, 8'h10, 8'hFF, 8'h00, lat, stalls, confl);
        tests++; if (confl !== 1) begin fails++; $display("FAIL fetch_load_conflict got %0d want 1", confl); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL fetch_load_latency got %0d want 4", lat); end
        tests++; if (d_rdata0 !== 8'h12) begin fails++; $display("FAIL fetch_load_data got %h want 12", d_rdata0); end
        tests++; if (instr_rdata0 !== 16'h3456) begin fails++; $display("FAIL fetch_load_no_fetch got %h want 3456", instr_rdata0); end
        do_op(0, 0, 1, 1, 8'h00, 8'h10, 8'h99, lat, stalls, confl);
        tests++; if (confl !== 1) begin fails++; $display("FAIL rd_wr_conflict got %0d want 1", confl); end
        tests++; if (lat !== 1) begin fails++; $display("FAIL rd_wr_latency got %0d want 1", lat); end
        tests++; if (d_rdata0 !== 8'h12) begin fails++; $display("FAIL rd_wr_rdata_held got %h want 12", d_rdata0); end
        do_op(0, 0, 1, 0, 8'h00, 8'h10, 8'h00, lat, stalls, confl);
        tests++; if (d_rdata0 !== 8'hA5) begin fails++; $display("FAIL rd_wr_mem_unchanged got %h want a5", d_rdata0); end
        tests++; if (confl !== 0) begin fails++; $display("FAIL plain_load_conflict got %0d want 0", confl); end
    endtask

    task automatic test_reset_mid();
        do_op(0, 0, 0, 1, 8'h00, 8'h20, 8'h11, lat, stalls, confl);
        d_wr = 1; d_addr = 8'h20; d_wdata = 8'h77;
        @(negedge clk);
        tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL mid_busy got %b want 1", busy0); end
        rst = 1;
        #1;
        tests++; if ({busy0, done0, conflict0, d_rdata0, instr_rdata0} !== 27'h0) begin fails++; $display("FAIL mid_reset_outputs got %h want 0", {busy0, done0, conflict0, d_rdata0, instr_rdata0}); end
        d_wr = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_op(0, 0, 1, 0, 8'h00, 8'h20, 8'h00, lat, stalls, confl);
        tests++; if (d_rdata0 !== 8'h11) begin fails++; $display("FAIL mid_reset_mem got %h want 11", d_rdata0); end
        tests++; if (lat !== 4) begin fails++; $display("FAIL post_reset_latency got %0d want 4", lat); end
    endtask

    task automatic test_zero_wait();
        do_op(1, 0, 1, 0, 8'h00, 8'h10, 8'h00, lat, stalls, confl);
        tests++; if (lat !== 2) begin fails++; $display("FAIL w0_load_latency got %0d want 2", lat); end
        tests++; if (d_rdata1 !== 8'hA5) begin fails++; $display("FAIL w0_load_data got %h want a5", d_rdata1); end
        do_op(1, 1, 0, 0, 8'hFF, 8'h00, 8'h00, lat, stalls, confl);
        tests++; if (lat !== 3) begin fails++; $display("FAIL w0_fetch_latency got %0d want 3", lat); end
        tests++; if (instr_rdata1 !== 16'h1234) begin fails++; $display("FAIL w0_fetch_data got %h want 1234", instr_rdata1); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_store();
        test_held_load();
        test_fetch_wrap();
        test_conflict();
        test_reset_mid();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
